mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, sets the address and data width.
REQ-002 Parameter LSU_MAX, default 4, sets the maximum consecutive contended LSU grants before the IFU is forced to win.
REQ-003 Parameter TIMEOUT, default 255, sets the maximum RESP-state cycles before a transaction is aborted.
REQ-004 Port list, one port per line (name, direction, width, meaning):
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- ifu_req  in  1  instruction-fetch read request.
- ifu_addr  in  WIDTH  fetch address.
- ifu_gnt  out  1  fetch request accepted.
- ifu_rvalid  out  1  fetch data valid.
- ifu_rdata  out  WIDTH  fetch data.
- lsu_req  in  1  load/store request.
- lsu_we  in  1  1 = store.
- lsu_addr  in  WIDTH  load/store address.
- lsu_wdata  in  WIDTH  store data.
- lsu_wmask  in  WIDTH/8  store byte mask.
- lsu_gnt  out  1  load/store accepted.
- lsu_rvalid  out  1  load data / store ack valid.
- lsu_rdata  out  WIDTH  load data.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  WIDTH  memory address.
- mem_wdata  out  WIDTH  memory write data.
- mem_wmask  out  WIDTH/8  memory byte mask.
- mem_gnt  in  1  memory accepted the request.
- mem_rvalid  in  1  memory response (read data or write ack).
- mem_rdata  in  WIDTH  memory read data.
- bus_err  out  1  one-cycle pulse on timeout abort.

Function
REQ-005 The FSM SHALL have exactly the states IDLE, REQ and RESP, and SHALL keep at most one memory transaction outstanding.
REQ-006 IDLE: with any request present, the arbiter SHALL pulse exactly one *_gnt combinationally, capture owner, we, addr, wdata and wmask into registers, and go to REQ on the next edge.
REQ-007 Arbitration: LSU wins by default; IFU wins when both request and lsu_streak == LSU_MAX; an uncontended requester always wins.
REQ-008 lsu_streak SHALL increment, saturating at LSU_MAX, on each LSU grant made while ifu_req=1, and SHALL clear on each IFU grant.
REQ-009 IFU captures SHALL force we=0 and wmask=0.
REQ-010 REQ: mem_req=1 and mem_* SHALL be driven from the captured registers only; on mem_gnt=1 the FSM SHALL go to RESP.
REQ-011 Requester inputs SHALL be ignored outside the IDLE grant cycle.
REQ-012 mem_rvalid in IDLE or REQ SHALL be ignored.
REQ-013 RESP: on mem_rvalid=1, the owner's *_rvalid SHALL be 1 for that cycle, with *_rdata=mem_rdata, and the FSM SHALL go to IDLE.
REQ-014 The non-owner's rvalid SHALL stay 0 throughout.
REQ-015 The minimum latency is 3 cycles: gnt at cycle 0, mem_req visible at cycle 1, mem_gnt at cycle 1 or later, rvalid at cycle 2 or later. Back-to-back transactions SHALL be able to receive a new grant in the cycle after rvalid.
REQ-016 A RESP cycle counter SHALL clear on entering RESP.
REQ-017 If the counter reaches TIMEOUT without mem_rvalid, the arbiter SHALL pulse bus_err and the owner's *_rvalid for one cycle with *_rdata=32'hDEADBEEF, then return to IDLE.
REQ-018 mem_rvalid arriving in the same cycle as timeout SHALL take precedence, giving a normal completion with no bus_err.
REQ-019 *_rdata SHALL be 0 whenever the corresponding *_rvalid=0.
REQ-020 Outputs when not in REQ: mem_req=0 and mem_we=0.
REQ-021 mem_addr, mem_wdata and mem_wmask SHALL hold their last captured values.

Reset
REQ-022 rst_n=0 SHALL immediately force state=IDLE, lsu_streak=0, timeout counter=0, all captured registers=0, and all outputs=0, including in REQ or RESP.
REQ-023 A memory response arriving after reset release for a transaction aborted by reset SHALL be ignored, because the FSM is in IDLE.

Verification
REQ-024 LSU load, single request: lsu_req with addr 0x80000010; mem_gnt at cycle 1; mem_rvalid with rdata 0x12345678 at cycle 3 -> lsu_gnt at cycle 0, lsu_rvalid/lsu_rdata=0x12345678 at cycle 3, ifu_rvalid=0 throughout.
REQ-025 Starvation: ifu_req and lsu_req held continuously with LSU_MAX=4 -> grants L,L,L,L,I,L,L,L,L,I.
REQ-026 Store: lsu_we=1, addr 0x80001000, wdata 0xCAFEBABE, wmask 4'b0011 -> mem_we=1 with the same fields in REQ; ack routed to lsu_rvalid.
REQ-027 Timeout: mem_gnt given, mem_rvalid never given, TIMEOUT=8 -> owner rvalid with 0xDEADBEEF and bus_err at the 8th RESP cycle; a late mem_rvalid is ignored.
REQ-028 Reset mid-RESP: rst_n low during RESP -> all outputs 0 immediately; a later mem_rvalid produces no rvalid; the next IFU request completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master (IFU/LSU) arbiter onto a single-outstanding memory port, with
// LSU-priority plus anti-starvation streak and a RESP-phase timeout abort.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LSU_MAX = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ifu_req,
  input  logic [WIDTH-1:0]   ifu_addr,
  output logic               ifu_gnt,
  output logic               ifu_rvalid,
  output logic [WIDTH-1:0]   ifu_rdata,
  input  logic               lsu_req,
  input  logic               lsu_we,
  input  logic [WIDTH-1:0]   lsu_addr,
  input  logic [WIDTH-1:0]   lsu_wdata,
  input  logic [WIDTH/8-1:0] lsu_wmask,
  output logic               lsu_gnt,
  output logic               lsu_rvalid,
  output logic [WIDTH-1:0]   lsu_rdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [WIDTH-1:0]   mem_addr,
  output logic [WIDTH-1:0]   mem_wdata,
  output logic [WIDTH/8-1:0] mem_wmask,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [WIDTH-1:0]   mem_rdata,
  output logic               bus_err
);

  localparam int unsigned SW = $clog2(LSU_MAX + 1);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e             state_q, state_d;
  logic [SW-1:0]      streak_q, streak_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               owner_lsu_q, owner_lsu_d;
  logic               we_q, we_d;
  logic [WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic [WIDTH/8-1:0] wmask_q, wmask_d;

  logic               lsu_win;
  logic               rsp_valid;
  logic [WIDTH-1:0]   rsp_data;

  assign lsu_win   = lsu_req && !(ifu_req && (streak_q == SW'(LSU_MAX)));
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    cnt_d       = cnt_q;
    owner_lsu_d = owner_lsu_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    ifu_gnt     = 1'b0;
    lsu_gnt     = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    bus_err     = 1'b0;
    rsp_valid   = 1'b0;
    rsp_data    = '0;
    ifu_rvalid  = 1'b0;
    ifu_rdata   = '0;
    lsu_rvalid  = 1'b0;
    lsu_rdata   = '0;

    unique case (state_q)
      StIdle: begin
        // Grants are combinational, so they must also be masked while reset is held.
        if (rst_n && (ifu_req || lsu_req)) begin
          state_d = StReq;
          if (lsu_win) begin
            lsu_gnt     = 1'b1;
            owner_lsu_d = 1'b1;
            we_d        = lsu_we;
            addr_d      = lsu_addr;
            wdata_d     = lsu_wdata;
            wmask_d     = lsu_wmask;
            if (ifu_req && (streak_q != SW'(LSU_MAX))) streak_d = streak_q + SW'(1);
          end else begin
            ifu_gnt     = 1'b1;
            owner_lsu_d = 1'b0;
            we_d        = 1'b0;
            addr_d      = ifu_addr;
            wdata_d     = '0;
            wmask_d     = '0;
            streak_d    = '0;
          end
        end
      end
      StReq: begin
        mem_req = 1'b1;
        mem_we  = we_q;
        if (mem_gnt) begin
          state_d = StResp;
          cnt_d   = '0;
        end
      end
      StResp: begin
        // A real response wins over a timeout landing in the same cycle.
        if (mem_rvalid) begin
          rsp_valid = 1'b1;
          rsp_data  = mem_rdata;
          state_d   = StIdle;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_valid = 1'b1;
          rsp_data  = WIDTH'(32'hDEADBEEF);
          bus_err   = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (owner_lsu_q) begin
      lsu_rvalid = rsp_valid;
      lsu_rdata  = rsp_data;
    end else begin
      ifu_rvalid = rsp_valid;
      ifu_rdata  = rsp_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      streak_q    <= '0;
      cnt_q       <= '0;
      owner_lsu_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      cnt_q       <= cnt_d;
      owner_lsu_q <= owner_lsu_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
    end
  end

endmodule
